// File: rtl/msx_mouse_port.sv
// MSX general-purpose port bridge: joystick passthrough or MSX nibble mouse.
// Define MSX_MOUSE_ACCUM_EN to accumulate deltas between reads.
module msx_mouse_port #(
  parameter int NPORTS  = 2,
  parameter int TIMEOUT = 100000,
  parameter int DELTA_W = 9
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic [DELTA_W*NPORTS-1:0]   mouse_x,
  input  logic [DELTA_W*NPORTS-1:0]   mouse_y,
  input  logic [2*NPORTS-1:0]         mouse_btn,
  input  logic [NPORTS-1:0]           mouse_strobe,
  input  logic [6*NPORTS-1:0]         joy,
  input  logic [NPORTS-1:0]           port_str,
  output logic [6*NPORTS-1:0]         pin_out,
  output logic [6*NPORTS-1:0]         pin_oe,
  output logic [NPORTS-1:0]           mouse_mode
);

  localparam int SW = DELTA_W + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [SW-1:0] P_MAX = SW'(127);
  localparam logic signed [SW-1:0] P_MIN = SW'(-128);

  typedef enum logic [1:0] {S0, S1, S2, S3} st_t;

  function automatic logic [7:0] sat(input logic signed [SW-1:0] v);
    if (v > P_MAX) return 8'h7F;
    if (v < P_MIN) return 8'h80;
    return v[7:0];
  endfunction

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic                      r_str;
    logic                      r_str_d;
    logic                      r_mode;
    st_t                       r_st;
    logic [7:0]                r_ax;
    logic [7:0]                r_ay;
    logic [CW-1:0]             r_cnt;
    logic [3:0]                r_nib;
    logic [1:0]                r_btn;
    logic [5:0]                r_out;
    logic [5:0]                r_oe;

    logic signed [DELTA_W-1:0] w_x;
    logic signed [DELTA_W-1:0] w_y;
    logic [5:0]                w_joy;
    logic                      w_stb;
    logic                      w_mode_nx;
    logic                      w_tog;
    logic                      w_clr;
    logic signed [SW-1:0]      w_bx;
    logic signed [SW-1:0]      w_by;
    logic [7:0]                w_sx;
    logic [7:0]                w_sy;
    logic [3:0]                w_nib;
    logic [3:0]                w_nib_nx;
    logic [1:0]                w_btn_nx;

    assign w_x   = mouse_x[p*DELTA_W +: DELTA_W];
    assign w_y   = mouse_y[p*DELTA_W +: DELTA_W];
    assign w_joy = joy[6*p +: 6];
    assign w_stb = mouse_strobe[p];
    assign w_tog = r_str ^ r_str_d;
    assign w_clr = w_tog && (r_st == S3);

    // Any joystick activity wins over a simultaneous mouse strobe
    assign w_mode_nx = (|w_joy) ? 1'b0 : (w_stb ? 1'b1 : r_mode);

    always_comb begin
      w_bx = '0;
      w_by = '0;
`ifdef MSX_MOUSE_ACCUM_EN
      if (!w_clr) begin
        w_bx = SW'($signed(r_ax));
        w_by = SW'($signed(r_ay));
      end
`endif
      w_sx = sat(w_bx - SW'(w_x));
      w_sy = sat(w_by + SW'(w_y));
      case (r_st)
        S0:      w_nib = r_ax[7:4];
        S1:      w_nib = r_ax[3:0];
        S2:      w_nib = r_ay[7:4];
        default: w_nib = r_ay[3:0];
      endcase
      w_nib_nx = w_tog ? w_nib : r_nib;
      w_btn_nx = w_stb ? mouse_btn[2*p +: 2] : r_btn;
      if (!w_mode_nx) begin
        w_nib_nx = '0;
        w_btn_nx = '0;
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_str   <= 1'b0;
        r_str_d <= 1'b0;
        r_mode  <= 1'b0;
        r_st    <= S0;
        r_ax    <= '0;
        r_ay    <= '0;
        r_cnt   <= '0;
        r_nib   <= '0;
        r_btn   <= '0;
        r_out   <= '0;
        r_oe    <= '0;
      end else begin
        r_str   <= port_str[p];
        r_str_d <= r_str;
        r_mode  <= w_mode_nx;
        r_nib   <= w_nib_nx;
        r_btn   <= w_btn_nx;
        if (!w_mode_nx) begin
          r_st  <= S0;
          r_ax  <= '0;
          r_ay  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_tog) begin
            r_st  <= st_t'(r_st + 2'd1);
            r_cnt <= CW'(TIMEOUT);
          end else if (r_cnt == CW'(1)) begin
            r_st  <= S0;
            r_cnt <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
          if (w_stb) begin
            r_ax <= w_sx;
            r_ay <= w_sy;
          end else if (w_clr) begin
            r_ax <= '0;
            r_ay <= '0;
          end
        end
        if (w_mode_nx) begin
          r_oe  <= {w_btn_nx[1], w_btn_nx[0], 4'hF};
          r_out <= {2'b00, w_nib_nx};
        end else begin
          r_oe  <= w_joy & {6{~port_str[p]}};
          r_out <= '0;
        end
      end
    end

    assign pin_out[6*p +: 6] = r_out;
    assign pin_oe[6*p +: 6]  = r_oe;
    assign mouse_mode[p]     = r_mode;
  end

endmodule

// File: doc/msx_mouse_port.md
MSX_MOUSE_PORT -- requirements
Module: msx_mouse_port

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of independent MSX general-purpose ports (1..2).
REQ-002 SHALL have parameter TIMEOUT, default 100000, idle clk_sys cycles after which the nibble sequence restarts at state 0.
REQ-003 SHALL have parameter DELTA_W, default 9, signed width of each host mouse delta input.
REQ-004 clk_sys  input  1  system clock; the only clock, all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 mouse_x  input  DELTA_W*NPORTS  per-port signed X delta, positive = right.
REQ-007 mouse_y  input  DELTA_W*NPORTS  per-port signed Y delta, positive = up.
REQ-008 mouse_btn  input  2*NPORTS  per-port buttons {right,left}, active high.
REQ-009 mouse_strobe  input  NPORTS  per-port one-cycle pulse marking valid deltas and buttons.
REQ-010 joy  input  6*NPORTS  per-port joystick {b2,b1,right,left,down,up}, active high.
REQ-011 port_str  input  NPORTS  MSX pin-8 strobe per port, synchronous to clk_sys.
REQ-012 pin_out  output  6*NPORTS  per-port pin levels {pin7,pin6,pin4,pin3,pin2,pin1}.
REQ-013 pin_oe  output  6*NPORTS  per-pin drive enable; 0 = released (pulled high by the consumer).
REQ-014 mouse_mode  output  NPORTS  per-port mode flag, 1 = mouse protocol active.

Function
REQ-015 Each port SHALL be an independent instance of the logic below; ports SHALL share no state.
REQ-016 mouse_mode SHALL set on mouse_strobe and clear on any set bit of that port's joy; simultaneous events SHALL clear it.
REQ-017 Joystick mode: pin i SHALL be driven low (oe=1, out=0) when joy[i]=1 and port_str=0, else released (oe=0).
REQ-018 Mouse mode: pins 1-4 SHALL always be driven with the current nibble; pins 6/7 SHALL be driven low while the left/right button is pressed, else released.
REQ-019 Accumulators AX, AY SHALL hold 8-bit signed values; the added delta SHALL be -mouse_x (MSX positive = left) and +mouse_y.
REQ-020 The sum SHALL be formed at DELTA_W+1 bits and saturated to [-128,+127].
REQ-021 A nibble state machine S0..S3 SHALL advance on every change of the registered port_str (either edge), wrapping S3->S0.
REQ-022 Outputs per transition: S0->S1 AX[7:4], S1->S2 AX[3:0], S2->S3 AY[7:4], S3->S0 AY[3:0], and the S3->S0 transition SHALL zero AX and AY.
REQ-023 The new nibble SHALL appear on pin_out on the second rising clk_sys edge after port_str changes.
REQ-024 Each port_str transition SHALL reload a down-counter with TIMEOUT; when the counter reaches 1 the state SHALL return to S0 without clearing AX/AY.
REQ-025 If mouse_strobe coincides with the S3->S0 clear, AX/AY SHALL equal the new saturated delta only.
REQ-026 Leaving mouse mode SHALL set the state to S0 and zero AX, AY, and the timeout counter.

Reset
REQ-027 While reset_n=0: pin_oe=0, pin_out=0, mouse_mode=0, state S0, AX=AY=0, timeout=0, registered port_str=0.
REQ-028 Deasserting reset_n mid-sequence SHALL restart each port in joystick mode at S0.

Configuration
REQ-029 With macro MSX_MOUSE_ACCUM_EN defined, deltas SHALL accumulate with saturation as in REQ-019..020.
REQ-030 Without MSX_MOUSE_ACCUM_EN, each mouse_strobe SHALL overwrite AX/AY with the saturated new delta, with no accumulation.

Verification
REQ-031 Reset with reset_n=0, joy=6'h01 -> pin_oe=0, pin_out=0 and mouse_mode=0 on every port.
REQ-032 Joystick mode, joy=6'h01, port_str=0 -> pin1 oe=1 out=0; set port_str=1 -> pin1 oe=0.
REQ-033 Strobe mouse_x=-5, mouse_y=3, then toggle port_str 4 times -> nibbles 0x0,0x5,0x0,0x3; a fifth toggle -> 0x0.
REQ-034 With ACCUM_EN, strobe mouse_x=-100 twice -> AX saturates, so the first two nibbles read 0x7,0xF.
REQ-035 Toggle port_str once, then idle TIMEOUT cycles, then toggle again -> AX[7:4] is output again (state restarted at S0).
REQ-036 Port 0 in mouse mode while port 1 has joy=6'h10 -> port 0 keeps its sequence, port 1 pin6 is driven low, and mouse_mode=2'b01.
